// File: rtl/acc_bank_pkg.sv
// Shared types for the accumulator bank: command opcodes and sequencer states.
package acc_bank_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_CLR  = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_ROL  = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/acc_step.sv
// One-step datapath: next register value and carry-out for a single operation.
// Shift ops move exactly one bit; multi-bit shifts iterate this step.
module acc_step
  import acc_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] next_value,
  output logic             carry
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    next_value = value;
    carry      = 1'b0;
    unique case (op)
      OP_LOAD: next_value = load_data;
      OP_CLR:  next_value = '0;
      OP_INC: begin
        next_value = value + WIDTH'(1);
        carry      = &value;
      end
      OP_DEC: begin
        next_value = value - WIDTH'(1);
        carry      = (value == '0);
      end
      OP_SHL: begin
        next_value = {value[WIDTH-2:0], 1'b0};
        carry      = value[WIDTH-1];
      end
      OP_SHR: begin
        next_value = {1'b0, value[WIDTH-1:1]};
        carry      = value[0];
      end
      OP_ROL: begin
        next_value = {value[WIDTH-2:0], value[WIDTH-1]};
        carry      = value[WIDTH-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/accumulator_bank.sv
// Bank of DEPTH accumulators with single-cycle arithmetic and bit-serial
// shift/rotate; one command at a time, shared carry/zero flags.
module accumulator_bank
  import acc_bank_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int SEL_W = $clog2(DEPTH),
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic [AMT_W-1:0] cmd_amt,
  output logic             cmd_ready,
  input  logic             enable_output,
  input  logic [SEL_W-1:0] out_sel,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic [WIDTH-1:0] reg_a,
  output logic             cf,
  output logic             zf
);

  logic [WIDTH-1:0] regs [DEPTH];
  state_e           state;
  op_e              shift_op;
  logic [SEL_W-1:0] shift_sel;
  logic [AMT_W-1:0] remain;

  op_e              cmd_op_e;
  logic             cmd_is_shift;
  op_e              step_op;
  logic [SEL_W-1:0] step_sel;
  logic [WIDTH-1:0] step_in;
  logic [WIDTH-1:0] step_value;
  logic             step_carry;

  assign cmd_op_e     = op_e'(cmd_op);
  assign cmd_is_shift = cmd_op_e inside {OP_SHL, OP_SHR, OP_ROL};

  // While shifting, the step unit iterates the captured command instead of the live one.
  assign step_op  = (state == ST_SHIFT) ? shift_op  : cmd_op_e;
  assign step_sel = (state == ST_SHIFT) ? shift_sel : cmd_sel;
  assign step_in  = regs[step_sel];

  acc_step #(.WIDTH(WIDTH)) u_step (
    .op         (step_op),
    .value      (step_in),
    .load_data  (bus_in),
    .next_value (step_value),
    .carry      (step_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is reset too, since the bank must read all-zero the moment rst rises.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      shift_op  <= OP_NOP;
      shift_sel <= '0;
      remain    <= '0;
      cf        <= 1'b0;
      zf        <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every read sees pre-edge values.
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_op_e != OP_NOP) begin
            if (cmd_is_shift && cmd_amt == '0) begin
              cf <= 1'b0;
              zf <= (step_in == '0);
            end else begin
              regs[cmd_sel] <= step_value;
              if (cmd_is_shift && cmd_amt > AMT_W'(1)) begin
                state     <= ST_SHIFT;
                cmd_ready <= 1'b0;
                shift_op  <= cmd_op_e;
                shift_sel <= cmd_sel;
                remain    <= cmd_amt - AMT_W'(1);
              end else begin
                cf <= step_carry;
                zf <= (step_value == '0);
              end
            end
          end
        end
        ST_SHIFT: begin
          regs[shift_sel] <= step_value;
          remain          <= remain - AMT_W'(1);
          if (remain == AMT_W'(1)) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            cf        <= step_carry;
            zf        <= (step_value == '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus_out = enable_output ? regs[out_sel] : '0;
  assign bus_oe  = enable_output;
  assign reg_a   = regs[0];

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed self-checking bench for accumulator_bank (WIDTH=8, DEPTH=4).
module tb_accumulator_bank;
  import acc_bank_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_in;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [1:0] cmd_sel;
  logic [2:0] cmd_amt;
  logic       cmd_ready;
  logic       enable_output;
  logic [1:0] out_sel;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] reg_a;
  logic       cf;
  logic       zf;

  int n_cmp = 0;
  int n_bad = 0;

  accumulator_bank #(.WIDTH(8), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus_in        (bus_in),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .cmd_sel       (cmd_sel),
    .cmd_amt       (cmd_amt),
    .cmd_ready     (cmd_ready),
    .enable_output (enable_output),
    .out_sel       (out_sel),
    .bus_out       (bus_out),
    .bus_oe        (bus_oe),
    .reg_a         (reg_a),
    .cf            (cf),
    .zf            (zf)
  );

  always #5 clk = ~clk;

  // Present one command for exactly one rising edge, then return 1 time unit after it.
  task automatic send(input logic [2:0] op, input logic [1:0] sel,
                      input logic [2:0] amt, input logic [7:0] data);
    cmd_op = op; cmd_sel = sel; cmd_amt = amt; bus_in = data; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_sel = '0; cmd_amt = '0;
    bus_in = '0; enable_output = 1'b0; out_sel = '0;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    n_cmp++; if ({cf, zf} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got cf,zf=%b want 00", {cf, zf}); end
    n_cmp++; if (reg_a !== 8'h00) begin n_bad++; $display("FAIL reset_reg_a: got %h want 00", reg_a); end
    n_cmp++; if ({bus_oe, bus_out} !== 9'h000) begin n_bad++; $display("FAIL reset_bus: got oe=%b out=%h want 0/00", bus_oe, bus_out); end
    rst = 1'b0;
  endtask

  task automatic test_load_read;
    send(OP_LOAD, 2'd2, 3'd0, 8'hA5);
    enable_output = 1'b1; out_sel = 2'd2; #1;
    n_cmp++; if (bus_out !== 8'hA5) begin n_bad++; $display("FAIL load_r2: got %h want a5", bus_out); end
    n_cmp++; if (bus_oe !== 1'b1) begin n_bad++; $display("FAIL load_oe: got %b want 1", bus_oe); end
    n_cmp++; if ({cf, zf} !== 2'b00) begin n_bad++; $display("FAIL load_flags: got cf,zf=%b want 00", {cf, zf}); end
    n_cmp++; if (reg_a !== 8'h00) begin n_bad++; $display("FAIL load_reg_a: got %h want 00", reg_a); end
    enable_output = 1'b0; #1;
    n_cmp++; if ({bus_oe, bus_out} !== 9'h000) begin n_bad++; $display("FAIL oe_off: got oe=%b out=%h want 0/00", bus_oe, bus_out); end
  endtask

  task automatic test_inc_dec;
    send(OP_LOAD, 2'd0, 3'd0, 8'hFF);
    n_cmp++; if (reg_a !== 8'hFF) begin n_bad++; $display("FAIL load_r0: got %h want ff", reg_a); end
    send(OP_INC, 2'd0, 3'd0, 8'h00);
    n_cmp++; if ({reg_a, cf, zf} !== {8'h00, 2'b11}) begin n_bad++; $display("FAIL inc_wrap: got %h cf,zf=%b want 00 11", reg_a, {cf, zf}); end
    send(OP_NOP, 2'd0, 3'd0, 8'h55);
    n_cmp++; if ({reg_a, cf, zf} !== {8'h00, 2'b11}) begin n_bad++; $display("FAIL nop_hold: got %h cf,zf=%b want 00 11", reg_a, {cf, zf}); end
    send(OP_DEC, 2'd0, 3'd0, 8'h00);
    n_cmp++; if ({reg_a, cf, zf} !== {8'hFF, 2'b10}) begin n_bad++; $display("FAIL dec_wrap: got %h cf,zf=%b want ff 10", reg_a, {cf, zf}); end
    send(OP_DEC, 2'd0, 3'd0, 8'h00);
    n_cmp++; if ({reg_a, cf, zf} !== {8'hFE, 2'b00}) begin n_bad++; $display("FAIL dec_plain: got %h cf,zf=%b want fe 00", reg_a, {cf, zf}); end
  endtask

  task automatic test_shl_busy;
    send(OP_LOAD, 2'd1, 3'd0, 8'h81);
    enable_output = 1'b1; out_sel = 2'd1;
    send(OP_SHL, 2'd1, 3'd3, 8'h00);
    n_cmp++; if ({cmd_ready, bus_out} !== {1'b0, 8'h02}) begin n_bad++; $display("FAIL shl_step1: got rdy=%b r1=%h want 0 02", cmd_ready, bus_out); end
    // A command offered while busy must be dropped.
    cmd_op = OP_LOAD; cmd_sel = 2'd1; bus_in = 8'hEE; cmd_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({cmd_ready, bus_out} !== {1'b0, 8'h04}) begin n_bad++; $display("FAIL shl_step2: got rdy=%b r1=%h want 0 04", cmd_ready, bus_out); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_cmp++; if ({cmd_ready, bus_out, cf, zf} !== {1'b1, 8'h08, 2'b00}) begin n_bad++; $display("FAIL shl_done: got rdy=%b r1=%h cf,zf=%b want 1 08 00", cmd_ready, bus_out, {cf, zf}); end
    @(posedge clk); #1;
    n_cmp++; if (bus_out !== 8'h08) begin n_bad++; $display("FAIL busy_ignored: got r1=%h want 08", bus_out); end
  endtask

  task automatic test_rol_shr;
    out_sel = 2'd3;
    send(OP_LOAD, 2'd3, 3'd0, 8'h81);
    send(OP_ROL, 2'd3, 3'd1, 8'h00);
    n_cmp++; if ({cmd_ready, bus_out, cf, zf} !== {1'b1, 8'h03, 2'b10}) begin n_bad++; $display("FAIL rol1: got rdy=%b r3=%h cf,zf=%b want 1 03 10", cmd_ready, bus_out, {cf, zf}); end
    send(OP_CLR, 2'd2, 3'd0, 8'h00);
    n_cmp++; if ({cf, zf} !== 2'b01) begin n_bad++; $display("FAIL clr_flags: got cf,zf=%b want 01", {cf, zf}); end
    send(OP_SHR, 2'd3, 3'd0, 8'h00);
    n_cmp++; if ({bus_out, cf, zf} !== {8'h03, 2'b00}) begin n_bad++; $display("FAIL shr0: got r3=%h cf,zf=%b want 03 00", bus_out, {cf, zf}); end
    send(OP_SHR, 2'd3, 3'd2, 8'h00);
    n_cmp++; if ({cmd_ready, bus_out} !== {1'b0, 8'h01}) begin n_bad++; $display("FAIL shr2_step1: got rdy=%b r3=%h want 0 01", cmd_ready, bus_out); end
    @(posedge clk); #1;
    n_cmp++; if ({cmd_ready, bus_out, cf, zf} !== {1'b1, 8'h00, 2'b11}) begin n_bad++; $display("FAIL shr2_done: got rdy=%b r3=%h cf,zf=%b want 1 00 11", cmd_ready, bus_out, {cf, zf}); end
  endtask

  task automatic test_reset_mid_shift;
    logic [7:0] seen;
    send(OP_LOAD, 2'd2, 3'd0, 8'h55);
    send(OP_DEC, 2'd3, 3'd0, 8'h00);
    n_cmp++; if ({cf, zf} !== 2'b10) begin n_bad++; $display("FAIL pre_rst_flags: got cf,zf=%b want 10", {cf, zf}); end
    send(OP_LOAD, 2'd1, 3'd0, 8'hF0);
    out_sel = 2'd1;
    send(OP_SHR, 2'd1, 3'd7, 8'h00);
    @(posedge clk); #1;
    n_cmp++; if ({cmd_ready, bus_out} !== {1'b0, 8'h3C}) begin n_bad++; $display("FAIL shr7_mid: got rdy=%b r1=%h want 0 3c", cmd_ready, bus_out); end
    #2 rst = 1'b1; #1;
    n_cmp++; if ({cmd_ready, cf, zf} !== 3'b100) begin n_bad++; $display("FAIL rst_async: got rdy,cf,zf=%b want 100", {cmd_ready, cf, zf}); end
    for (int i = 0; i < 4; i++) begin
      out_sel = 2'(i); #0.5;
      seen = bus_out;
      n_cmp++; if (seen !== 8'h00) begin n_bad++; $display("FAIL rst_reg%0d: got %h want 00", i, seen); end
    end
    rst = 1'b0;
    send(OP_INC, 2'd0, 3'd0, 8'h00);
    n_cmp++; if ({reg_a, cf, zf} !== {8'h01, 2'b00}) begin n_bad++; $display("FAIL first_edge_cmd: got %h cf,zf=%b want 01 00", reg_a, {cf, zf}); end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_inc_dec();
    test_shl_busy();
    test_rol_shr();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/accumulator_bank.md
ACCUMULATOR_BANK -- requirements
Module: accumulator_bank

Interface
REQ-001 Parameter WIDTH, default 8, register and bus width; legal range 4..32.
REQ-002 Parameter DEPTH, default 4, number of registers; power of two, 2..16.
REQ-003 Derived SEL_W = clog2(DEPTH) and AMT_W = clog2(WIDTH).
REQ-004 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Port bus_in  in  WIDTH  data source for LOAD.
REQ-007 Port cmd_valid  in  1  command request.
REQ-008 Port cmd_op  in  3  opcode: 0 NOP, 1 LOAD, 2 CLR, 3 INC, 4 DEC, 5 SHL, 6 SHR, 7 ROL.
REQ-009 Port cmd_sel  in  SEL_W  target register index.
REQ-010 Port cmd_amt  in  AMT_W  shift/rotate amount, used by ops 5-7 only.
REQ-011 Port cmd_ready  out  1  command may be accepted this cycle.
REQ-012 Port enable_output  in  1  drive the selected register onto bus_out.
REQ-013 Port out_sel  in  SEL_W  register index read onto bus_out.
REQ-014 Port bus_out  out  WIDTH  read data.
REQ-015 Port bus_oe  out  1  bus_out valid; equals enable_output.
REQ-016 Port reg_a  out  WIDTH  register 0 contents, always visible.
REQ-017 Port cf  out  1  carry flag.
REQ-018 Port zf  out  1  zero flag.

Function
REQ-019 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; cmd_op, cmd_sel and cmd_amt are captured at that edge.
REQ-020 cmd_ready SHALL be 1 exactly when the FSM is in IDLE.
REQ-021 FSM states SHALL be IDLE and SHIFT; IDLE->SHIFT on accepting op 5-7 with amt >= 2; SHIFT->IDLE on the edge at which the remaining count reaches 0.
REQ-022 LOAD, CLR, INC, DEC SHALL update the target register at the accept edge (latency 1); NOP changes nothing, including flags.
REQ-023 INC SHALL wrap all-ones to 0 with cf=1; DEC SHALL wrap 0 to all-ones with cf=1; otherwise cf=0.
REQ-024 LOAD and CLR SHALL set cf=0.
REQ-025 SHL/SHR/ROL SHALL move one bit per cycle: first step at the accept edge, total amt edges, cmd_ready low for amt-1 cycles.
REQ-026 SHL fills LSB with 0, SHR (logical) fills MSB with 0, ROL moves MSB to LSB; cf = bit moved out on the final step.
REQ-027 Shift/rotate with amt=0 SHALL complete at the accept edge with value unchanged, cf=0, zf updated.
REQ-028 zf SHALL equal (result == 0) and, with cf, update only on the edge an op completes; flags hold otherwise.
REQ-029 bus_out SHALL be registers[out_sel] when enable_output=1, else 0; combinational read, so a same-edge write is visible from the following cycle.
REQ-030 Reading the shift target during SHIFT SHALL return the intermediate value.
REQ-031 cmd_valid during SHIFT SHALL be ignored; no queueing.

Reset
REQ-032 rst=1 SHALL immediately clear all registers, cf, zf and the shift counter, and force IDLE (cmd_ready=1), including mid-shift.
REQ-033 After reset release, a command is acceptable on the first rising edge.

Structure
REQ-034 Package acc_bank_pkg SHALL hold the opcode enum and FSM state enum.
REQ-035 Sub-module acc_step (combinational) SHALL compute one-step next value and carry for a given op, shared by single-cycle and shift paths.

Verification (WIDTH=8, DEPTH=4)
REQ-036 LOAD 0xA5 into r2, then enable_output with out_sel=2 -> bus_out=0xA5, bus_oe=1, cf=0, zf=0; reg_a=0x00.
REQ-037 LOAD 0xFF into r0, INC r0 -> reg_a=0x00, cf=1, zf=1; DEC r0 -> 0xFF, cf=1, zf=0.
REQ-038 LOAD 0x81 into r1, SHL amt=3 -> cmd_ready low 2 cycles, r1=0x08, cf=0 after third edge; cmd_valid during busy ignored.
REQ-039 LOAD 0x81 into r3, ROL amt=1 -> r3=0x03, cf=1, cmd_ready never drops; SHR amt=0 -> r3 unchanged, cf=0.
REQ-040 Start SHR amt=7 on r1=0xF0, assert rst after 2 cycles -> all registers 0, cf=zf=0, cmd_ready=1 without waiting for a clock edge.
